z80_io_master: RTL and testbench

Z80_IO_MASTER -- requirements
Module: z80_io_master

---
 rtl/z80_io_master.sv | 144 ++++++++++++++
 tb/tb_z80_io_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_master.sv
// Z80 I/O bus master: runs one IN/OUT cycle (T1, T2, TW..., T3) per accepted request.
// Optional wait-state timeout is enabled by defining Z80_IOM_TIMEOUT_EN.
module z80_io_master #(
    parameter int unsigned TDIV     = 2,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic [7:0] address,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in,
    output logic       iorq_n,
    output logic       rd_n,
    output logic       wr_n,
    input  logic       wait_n
);

    typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3} state_e;

    state_e     state_q, state_d;
    logic [3:0] sub_q, sub_d;
    logic       started_q;
    logic       write_q;
    logic [7:0] addr_q, wdata_q, rdata_q;
    logic       rsp_valid_q, rsp_valid_d;
    logic       accept, sub_last, strobe, tw_expired, abort;

    assign sub_last = (sub_q == 4'(TDIV - 1));
    assign accept   = req_valid && req_ready;
    assign abort    = (state_q == StTw) && sub_last && !wait_n && tw_expired;

`ifdef Z80_IOM_TIMEOUT_EN
    logic [7:0] tw_cnt_q, tw_cnt_d;
    logic       timeout_q;

    // Counts completed TW states of the current cycle.
    assign tw_expired = (tw_cnt_q == 8'(WAIT_MAX - 1));

    always_comb begin
        tw_cnt_d = tw_cnt_q;
        if (state_q == StT2) begin
            tw_cnt_d = '0;
        end else if (state_q == StTw && sub_last) begin
            tw_cnt_d = tw_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tw_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            tw_cnt_q  <= tw_cnt_d;
            timeout_q <= abort;
        end
    end

    assign rsp_timeout = timeout_q;
`else
    logic [7:0] unused_wait_max;
    assign unused_wait_max = 8'(WAIT_MAX);
    assign tw_expired      = 1'b0;
    assign rsp_timeout     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        rsp_valid_d = 1'b0;
        if (state_q != StIdle) begin
            sub_d = sub_last ? 4'd0 : sub_q + 4'd1;
        end
        unique case (state_q)
            StIdle: if (accept) state_d = StT1;
            StT1:   if (sub_last) state_d = StT2;
            StT2:   if (sub_last) state_d = StTw;
            StTw: begin
                if (sub_last) begin
                    if (wait_n) begin
                        state_d = StT3;
                    end else if (abort) begin
                        state_d     = StIdle;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            StT3: begin
                if (sub_last) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sub_q       <= '0;
            started_q   <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            started_q   <= 1'b1;
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == StT3 && sub_last && !write_q) begin
                rdata_q <= d_in;
            end
        end
    end

    // Strobes decode straight from state so an async reset releases them at once.
    assign strobe    = (state_q == StT2) || (state_q == StTw) || (state_q == StT3);
    assign iorq_n    = !strobe;
    assign rd_n      = !(strobe && !write_q);
    assign wr_n      = !(strobe && write_q);
    assign d_oe      = write_q && (state_q != StIdle);
    assign d_out     = wdata_q;
    assign address   = addr_q;
    assign req_ready = (state_q == StIdle) && started_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_z80_io_master.sv
// Self-checking bench for z80_io_master: directed bus cycles plus randomized IN/OUT traffic
// scored against a timing/data model derived from the Z80 I/O cycle rules.
module tb_z80_io_master;

    localparam int T  = 2;
    localparam int WM = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_timeout;
    logic [7:0] rsp_rdata, address, d_out, d_in;
    logic       d_oe, iorq_n, rd_n, wr_n, wait_n;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model_rdata = 8'h00;

    z80_io_master #(
        .TDIV     (T),
        .WAIT_MAX (WM)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .address     (address),
        .d_out       (d_out),
        .d_oe        (d_oe),
        .d_in        (d_in),
        .iorq_n      (iorq_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .wait_n      (wait_n)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle. extra = TW states with wait_n low beyond the automatic one;
    // stuck = wait_n never released; b2b = return inside the rsp_valid clock.
    task automatic run_io(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] din, input int extra, input bit stuck,
                          input bit b2b);
        int   lat, iorq_lo, rd_lo, wr_lo, oe_cnt, addr_bad, dout_bad;
        int   exp_lat, exp_lo, exp_oe, budget;
        logic exp_to;
        if (stuck) begin
            exp_lat = (2 + WM) * T + 1;
            exp_lo  = (1 + WM) * T;
            exp_to  = 1'b1;
        end else begin
            exp_lat = (4 + extra) * T + 1;
            exp_lo  = (3 + extra) * T;
            exp_to  = 1'b0;
            if (!wr) model_rdata = din;
        end
        exp_oe = wr ? exp_lat - 1 : 0;

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        d_in      = din;
        wait_n    = 1'b0;
        check("accept_ready", {31'd0, req_ready}, 32'd1);

        lat = 0; iorq_lo = 0; rd_lo = 0; wr_lo = 0; oe_cnt = 0; addr_bad = 0; dout_bad = 0;
        budget = exp_lat + 16;
        for (int c = 1; c <= budget && lat == 0; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            wait_n = (!stuck && c > (2 + extra) * T) ? 1'b1 : 1'b0;
            if (iorq_n === 1'b0) iorq_lo++;
            if (rd_n === 1'b0) rd_lo++;
            if (wr_n === 1'b0) wr_lo++;
            if (d_oe === 1'b1) begin
                oe_cnt++;
                if (d_out !== wdata) dout_bad++;
            end
            if (address !== addr) addr_bad++;
            if (rsp_valid === 1'b1) lat = c;
        end

        check("latency", lat, exp_lat);
        check("iorq_low_clocks", iorq_lo, exp_lo);
        check("rd_low_clocks", rd_lo, wr ? 0 : exp_lo);
        check("wr_low_clocks", wr_lo, wr ? exp_lo : 0);
        check("d_oe_clocks", oe_cnt, exp_oe);
        check("d_out_bad_clocks", dout_bad, 0);
        check("address_bad_clocks", addr_bad, 0);
        check("rsp_release", {29'd0, iorq_n, rd_n, wr_n}, 32'd7);
        check("rsp_d_oe", {31'd0, d_oe}, 32'd0);
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
        check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, model_rdata});

        if (!b2b) begin
            @(posedge clk); #1;
            check("rsp_pulse_one_clock", {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        int rsp_seen;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        d_in      = 8'h00;
        wait_n    = 1'b1;

        #3;
        check("reset_strobes", {29'd0, iorq_n, rd_n, wr_n}, 32'd7);
        check("reset_outputs", {28'd0, d_oe, rsp_valid, rsp_timeout, req_ready}, 32'd0);
        check("reset_address_dout", {16'd0, address, d_out}, 32'd0);
        check("reset_rdata", {24'd0, rsp_rdata}, 32'd0);

        #19 reset_n = 1'b1;
        #1;
        check("ready_before_first_clock", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_after_first_clock", {31'd0, req_ready}, 32'd1);

        // OUT 0x11 <- 0x06, no extra waits
        run_io(1'b1, 8'h11, 8'h06, 8'h3C, 0, 1'b0, 1'b0);
        check("out_d_out_value", {24'd0, d_out}, 32'h06);
        // IN 0x10, d_in = 0xA5
        run_io(1'b0, 8'h10, 8'h00, 8'hA5, 0, 1'b0, 1'b0);
        // IN 0x11 with three extra TW states
        run_io(1'b0, 8'h11, 8'h00, 8'h5E, 3, 1'b0, 1'b0);

`ifdef Z80_IOM_TIMEOUT_EN
        run_io(1'b0, 8'h10, 8'h00, 8'hC3, 0, 1'b1, 1'b0);
        run_io(1'b1, 8'h11, 8'h77, 8'h00, 0, 1'b1, 1'b0);
`endif

        // Reset pulsed during T2 of an OUT cycle
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h11;
        req_wdata = 8'h5A;
        wait_n    = 1'b1;
        check("rst_accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (T) @(posedge clk);
        #1;
        check("rst_t2_wr_low", {29'd0, iorq_n, rd_n, wr_n}, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_strobes", {29'd0, iorq_n, rd_n, wr_n}, 32'd7);
        check("rst_async_d_oe", {31'd0, d_oe}, 32'd0);
        check("rst_async_address", {24'd0, address}, 32'd0);
        model_rdata = 8'h00;
        rsp_seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) rsp_seen++;
        end
        #3 reset_n = 1'b1;
        for (int c = 0; c < 4 * T + 4; c++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) rsp_seen++;
        end
        check("rst_no_rsp_valid", rsp_seen, 0);
        run_io(1'b1, 8'h10, 8'hE1, 8'h00, 1, 1'b0, 1'b0);

        // Back-to-back: second request presented in the rsp_valid clock
        run_io(1'b1, 8'h11, 8'h42, 8'h00, 0, 1'b0, 1'b1);
        run_io(1'b0, 8'h10, 8'h00, 8'h9B, 0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 16; i++) begin
            logic [7:0] a, wd, di;
            logic       w;
            int         e;
            bit         chain;
            a     = 8'($urandom);
            wd    = 8'($urandom);
            di    = 8'($urandom);
            w     = 1'($urandom);
            e     = int'($urandom_range(3, 0));
            chain = 1'($urandom);
            run_io(w, a, wd, di, e, 1'b0, chain);
        end
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
